// File: rtl/dlx_mem_arbiter.sv
// Shares one memory port between DLX instruction fetch and data access; data wins unless fetch has waited DC_BURST_MAX grants.
// Latency: grant registers mem_* one cycle after request; ack and rdata one cycle after mem_ready (2-cycle minimum round trip).
// Backpressure: requesters stall on ic_wait/dc_wait until ack; mem_* held stable until mem_ready.
module dlx_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int DC_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ack,
    output logic              ic_wait,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ack,
    output logic              dc_wait,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int STREAK_W = $clog2(DC_BURST_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IC_BUSY = 2'd1,
        DC_BUSY = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_grant_ic;
    logic                w_grant_dc;
    logic                w_done;
    logic                w_ic_eff;
    logic                w_dc_eff;
    logic                w_streak_full;
    logic [STREAK_W-1:0] r_streak;

    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_ic_rdata;
    logic [DATA_W-1:0]   r_dc_rdata;
    logic                r_ic_ack;
    logic                r_dc_ack;

    // A requester still holds its request during its own ack cycle; mask it there.
    assign w_ic_eff      = ic_req & ~r_ic_ack;
    assign w_dc_eff      = dc_req & ~r_dc_ack;
    assign w_streak_full = (r_streak == STREAK_W'(DC_BURST_MAX));

    assign ic_wait   = ic_req & ~r_ic_ack;
    assign dc_wait   = dc_req & ~r_dc_ack;
    assign ic_ack    = r_ic_ack;
    assign dc_ack    = r_dc_ack;
    assign ic_rdata  = r_ic_rdata;
    assign dc_rdata  = r_dc_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Arbitration and completion detect; mem_ready is only honoured while busy.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_ic  = 1'b0;
        w_grant_dc  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dc_eff && !(w_ic_eff && w_streak_full)) begin
                    w_grant_dc  = 1'b1;
                    w_state_nxt = DC_BUSY;
                end else if (w_ic_eff) begin
                    w_grant_ic  = 1'b1;
                    w_state_nxt = IC_BUSY;
                end
            end
            IC_BUSY, DC_BUSY: begin
                if (mem_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory port registers, read-data capture and one-cycle ack pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ic_rdata  <= '0;
            r_dc_rdata  <= '0;
            r_ic_ack    <= 1'b0;
            r_dc_ack    <= 1'b0;
        end else begin
            r_ic_ack <= 1'b0;
            r_dc_ack <= 1'b0;
            if (w_grant_ic) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= ic_addr;
            end
            if (w_grant_dc) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= dc_we;
                r_mem_addr  <= dc_addr;
                r_mem_wdata <= dc_wdata;
            end
            if (w_done) begin
                r_mem_req <= 1'b0;
                if (r_state == IC_BUSY) begin
                    r_ic_rdata <= mem_rdata;
                    r_ic_ack   <= 1'b1;
                end else begin
                    r_dc_ack <= 1'b1;
                    // Writes leave the last read value visible to the pipeline.
                    if (!r_mem_we) r_dc_rdata <= mem_rdata;
                end
            end
        end
    end

    // Count consecutive data grants taken while fetch was asking; saturates at the bound.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_streak <= '0;
        end else if (w_grant_ic) begin
            r_streak <= '0;
        end else if (w_grant_dc) begin
            if (!ic_req)             r_streak <= '0;
            else if (!w_streak_full) r_streak <= r_streak + STREAK_W'(1);
        end
    end

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Directed testbench for dlx_mem_arbiter: reset, fetch, contention, starvation bound, write/rdata, spurious ready.
// Inputs driven and outputs sampled on the falling edge; DUT acts on the rising edge.
// Memory readiness is driven explicitly per scenario.
module tb_dlx_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic [31:0] ic_rdata;
    logic        ic_ack;
    logic        ic_wait;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [31:0] dc_rdata;
    logic        dc_ack;
    logic        dc_wait;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_checks = 0;
    int n_fail   = 0;

    dlx_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DC_BURST_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_rdata  (ic_rdata),
        .ic_ack    (ic_ack),
        .ic_wait   (ic_wait),
        .dc_req    (dc_req),
        .dc_we     (dc_we),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dc_rdata  (dc_rdata),
        .dc_ack    (dc_ack),
        .dc_wait   (dc_wait),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0;
        dc_addr = '0; dc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        #2;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %0h want 0", mem_req); end
        n_checks++; if ({ic_ack, dc_ack} !== 2'b00) begin n_fail++; $display("FAIL rst_acks: got %b want 00", {ic_ack, dc_ack}); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        n_checks++; if ({ic_rdata, dc_rdata} !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", {ic_rdata, dc_rdata}); end
        tick;
        rst_n = 1'b1;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h40; dc_wdata = 32'h77;
        tick;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL rst_pre_grant: got req=%0h addr=%h want 1/40", mem_req, mem_addr); end
        // Reset lands mid DC_BUSY: everything clears without waiting for a clock edge.
        rst_n = 1'b0; dc_req = 1'b0;
        #1;
        n_checks++; if ({mem_req, mem_we, ic_ack, dc_ack, ic_wait, dc_wait} !== 6'b0) begin n_fail++; $display("FAIL rst_async_ctl: got %b want 000000", {mem_req, mem_we, ic_ack, dc_ack, ic_wait, dc_wait}); end
        n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_async_data: got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata); end
        tick;
        rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hFFFF;
        tick;
        n_checks++; if (dc_ack !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_abandon1: got ack=%0h req=%0h want 0/0", dc_ack, mem_req); end
        tick;
        n_checks++; if (dc_ack !== 1'b0 || dc_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_abandon2: got ack=%0h rdata=%h want 0/0", dc_ack, dc_rdata); end
        mem_ready = 1'b0;
        tick;
    endtask

    task automatic test_single_fetch;
        ic_req = 1'b1; ic_addr = 32'h100;
        #1;
        n_checks++; if (ic_wait !== 1'b1) begin n_fail++; $display("FAIL fetch_wait_req: got %0h want 1", ic_wait); end
        tick;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_grant: got req=%0h addr=%h we=%0h want 1/100/0", mem_req, mem_addr, mem_we); end
        n_checks++; if (ic_ack !== 1'b0 || ic_wait !== 1'b1) begin n_fail++; $display("FAIL fetch_busy1: got ack=%0h wait=%0h want 0/1", ic_ack, ic_wait); end
        tick;
        n_checks++; if (mem_req !== 1'b1 || ic_wait !== 1'b1) begin n_fail++; $display("FAIL fetch_busy2: got req=%0h wait=%0h want 1/1", mem_req, ic_wait); end
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick;
        n_checks++; if (ic_ack !== 1'b1 || ic_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_ack: got ack=%0h rdata=%h want 1/deadbeef", ic_ack, ic_rdata); end
        n_checks++; if (ic_wait !== 1'b0 || mem_req !== 1'b0 || dc_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_ack_side: got wait=%0h req=%0h dcack=%0h want 0/0/0", ic_wait, mem_req, dc_ack); end
        mem_ready = 1'b0; ic_req = 1'b0;
        tick;
        n_checks++; if (ic_ack !== 1'b0 || ic_rdata !== 32'hDEADBEEF || mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_after: got ack=%0h rdata=%h req=%0h want 0/deadbeef/0", ic_ack, ic_rdata, mem_req); end
    endtask

    task automatic test_simultaneous;
        ic_req = 1'b1; ic_addr = 32'h300;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h200; dc_wdata = 32'h55;
        tick;
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h55) begin n_fail++; $display("FAIL sim_dc_first: got req=%0h we=%0h addr=%h wdata=%h want 1/1/200/55", mem_req, mem_we, mem_addr, mem_wdata); end
        n_checks++; if (ic_wait !== 1'b1 || dc_wait !== 1'b1) begin n_fail++; $display("FAIL sim_waits: got ic=%0h dc=%0h want 1/1", ic_wait, dc_wait); end
        mem_ready = 1'b1; mem_rdata = 32'h0BAD;
        tick;
        n_checks++; if (dc_ack !== 1'b1 || ic_ack !== 1'b0 || mem_req !== 1'b0 || dc_wait !== 1'b0) begin n_fail++; $display("FAIL sim_dc_ack: got dcack=%0h icack=%0h req=%0h dcwait=%0h want 1/0/0/0", dc_ack, ic_ack, mem_req, dc_wait); end
        mem_ready = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        tick;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_we !== 1'b0 || dc_ack !== 1'b0) begin n_fail++; $display("FAIL sim_ic_next: got req=%0h addr=%h we=%0h dcack=%0h want 1/300/0/0", mem_req, mem_addr, mem_we, dc_ack); end
        mem_ready = 1'b1; mem_rdata = 32'hCAFE;
        tick;
        n_checks++; if (ic_ack !== 1'b1 || ic_rdata !== 32'hCAFE || dc_ack !== 1'b0) begin n_fail++; $display("FAIL sim_ic_ack: got ack=%0h rdata=%h dcack=%0h want 1/cafe/0", ic_ack, ic_rdata, dc_ack); end
        mem_ready = 1'b0; ic_req = 1'b0;
        tick;
    endtask

    // Fetch and data contend afresh in IDLE each round (each drops its request once
    // it has lost), so the only thing steering grants is the streak bound.
    task automatic test_starvation;
        logic [5:0]  exp_dc;
        logic [31:0] exp_addr;
        exp_dc = 6'b101111;
        for (int i = 0; i < 6; i++) begin
            ic_req = 1'b1; ic_addr = 32'h500;
            dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h600 + 32'(i * 4);
            exp_addr = exp_dc[i] ? (32'h600 + 32'(i * 4)) : 32'h500;
            tick;
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin n_fail++; $display("FAIL starve_grant%0d: got req=%0h addr=%h want 1/%h", i, mem_req, mem_addr, exp_addr); end
            if (exp_dc[i]) ic_req = 1'b0;
            else           dc_req = 1'b0;
            mem_ready = 1'b1; mem_rdata = 32'hA0 + 32'(i);
            tick;
            n_checks++; if (dc_ack !== exp_dc[i] || ic_ack !== !exp_dc[i]) begin n_fail++; $display("FAIL starve_ack%0d: got dc=%0h ic=%0h want %0h/%0h", i, dc_ack, ic_ack, exp_dc[i], !exp_dc[i]); end
            mem_ready = 1'b0; ic_req = 1'b0; dc_req = 1'b0;
            tick;
        end
        n_checks++; if (ic_rdata !== 32'hA4 || dc_rdata !== 32'hA5) begin n_fail++; $display("FAIL starve_rdata: got ic=%h dc=%h want a4/a5", ic_rdata, dc_rdata); end
    endtask

    task automatic test_write_preserves;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h400;
        tick;
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h400) begin n_fail++; $display("FAIL wp_read_grant: got req=%0h we=%0h addr=%h want 1/0/400", mem_req, mem_we, mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'h1234;
        tick;
        n_checks++; if (dc_ack !== 1'b1 || dc_rdata !== 32'h1234) begin n_fail++; $display("FAIL wp_read_ack: got ack=%0h rdata=%h want 1/1234", dc_ack, dc_rdata); end
        mem_ready = 1'b0; dc_req = 1'b0;
        tick;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h404; dc_wdata = 32'h99;
        tick;
        n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h99 || mem_addr !== 32'h404) begin n_fail++; $display("FAIL wp_write_grant: got we=%0h wdata=%h addr=%h want 1/99/404", mem_we, mem_wdata, mem_addr); end
        // Changing the request mid-transaction must not disturb the port.
        dc_addr = 32'h800; dc_wdata = 32'h11;
        mem_ready = 1'b1; mem_rdata = 32'hBAD0;
        tick;
        n_checks++; if (dc_ack !== 1'b1 || dc_rdata !== 32'h1234) begin n_fail++; $display("FAIL wp_write_ack: got ack=%0h rdata=%h want 1/1234", dc_ack, dc_rdata); end
        mem_ready = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        tick;
        n_checks++; if (dc_rdata !== 32'h1234 || dc_ack !== 1'b0) begin n_fail++; $display("FAIL wp_after: got rdata=%h ack=%0h want 1234/0", dc_rdata, dc_ack); end
    endtask

    task automatic test_spurious;
        mem_ready = 1'b1; mem_rdata = 32'h5555;
        tick;
        n_checks++; if ({ic_ack, dc_ack, mem_req} !== 3'b000) begin n_fail++; $display("FAIL spur_1: got acks/req=%b want 000", {ic_ack, dc_ack, mem_req}); end
        tick;
        n_checks++; if ({ic_ack, dc_ack, mem_req} !== 3'b000 || dc_rdata !== 32'h1234) begin n_fail++; $display("FAIL spur_2: got acks/req=%b rdata=%h want 000/1234", {ic_ack, dc_ack, mem_req}, dc_rdata); end
        mem_ready = 1'b0;
        // Still IDLE: a fresh fetch is granted on the next edge.
        ic_req = 1'b1; ic_addr = 32'h104;
        tick;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h104 || ic_ack !== 1'b0) begin n_fail++; $display("FAIL spur_idle_grant: got req=%0h addr=%h ack=%0h want 1/104/0", mem_req, mem_addr, ic_ack); end
        mem_ready = 1'b1; mem_rdata = 32'h7777;
        tick;
        n_checks++; if (ic_ack !== 1'b1 || ic_rdata !== 32'h7777) begin n_fail++; $display("FAIL spur_fetch_ack: got ack=%0h rdata=%h want 1/7777", ic_ack, ic_rdata); end
        mem_ready = 1'b0; ic_req = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_single_fetch;
        test_simultaneous;
        test_starvation;
        test_write_preserves;
        test_spurious;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
